// File: rtl/tdm_mux.sv
// Four-channel time-division multiplexer: captures four lanes on start and
// serialises them slot 0..3, each slot held for SLOT_CYCLES clocks.
module tdm_mux #(
  parameter int unsigned DATA_WIDTH  = 1,
  parameter int unsigned SLOT_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*DATA_WIDTH-1:0] mux_in,
  input  logic                    mux_start,
  input  logic                    mux_repeat,
  output logic [DATA_WIDTH-1:0]   mux_out,
  output logic [1:0]              mux_select,
  output logic                    mux_valid,
  output logic                    mux_frame,
  output logic                    mux_busy,
  output logic                    mux_done
);

  localparam int unsigned CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_CYCLES - 1);

  typedef logic [3:0][DATA_WIDTH-1:0] chan_t;
  typedef enum logic {IDLE, SEND} state_t;

  state_t           state;
  chan_t            shadow;
  chan_t            in_ch;
  logic [1:0]       slot;
  logic [1:0]       slot_nxt;
  logic [CNT_W-1:0] cnt;

  assign in_ch    = chan_t'(mux_in);
  assign slot_nxt = slot + 2'd1;

  // Outputs are loaded together with the slot they describe, so they always
  // reflect the slot currently on the wire.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      shadow     <= '0;
      slot       <= '0;
      cnt        <= '0;
      mux_out    <= '0;
      mux_select <= '0;
      mux_valid  <= 1'b0;
      mux_frame  <= 1'b0;
      mux_busy   <= 1'b0;
      mux_done   <= 1'b0;
    end else begin
      mux_frame <= 1'b0;
      mux_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (mux_start) begin
            state      <= SEND;
            shadow     <= in_ch;
            slot       <= '0;
            cnt        <= '0;
            mux_out    <= in_ch[0];
            mux_select <= '0;
            mux_valid  <= 1'b1;
            mux_busy   <= 1'b1;
            mux_frame  <= 1'b1;
          end
        end
        SEND: begin
          if (cnt != CNT_LAST) begin
            cnt <= cnt + CNT_W'(1);
          end else begin
            cnt <= '0;
            if (slot != 2'd3) begin
              slot       <= slot_nxt;
              mux_select <= slot_nxt;
              mux_out    <= shadow[slot_nxt];
            end else begin
              mux_done <= 1'b1;
              slot     <= '0;
              // Back-to-back frame: recapture and restart without a gap cycle.
              if (mux_repeat) begin
                shadow     <= in_ch;
                mux_out    <= in_ch[0];
                mux_select <= '0;
                mux_frame  <= 1'b1;
              end else begin
                state      <= IDLE;
                mux_out    <= '0;
                mux_select <= '0;
                mux_valid  <= 1'b0;
                mux_busy   <= 1'b0;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_mux.sv
// Self-checking bench for tdm_mux: directed vector tables, hand sequences for
// repeat/abort/short-slot corners, and random traffic against a frame-position model.
module tb_tdm_mux;

  logic        clk;
  logic        rst_n;
  logic [3:0]  in_a;
  logic        start_a, rep_a;
  logic [0:0]  out_a;
  logic [1:0]  sel_a;
  logic        valid_a, frame_a, busy_a, done_a;
  logic [31:0] in_b;
  logic        start_b, rep_b;
  logic [7:0]  out_b;
  logic [1:0]  sel_b;
  logic        valid_b, frame_b, busy_b, done_b;

  int total = 0;
  int bad   = 0;

  tdm_mux #(.DATA_WIDTH(1), .SLOT_CYCLES(4)) dut_a (
    .clk(clk), .reset_n(rst_n), .mux_in(in_a), .mux_start(start_a), .mux_repeat(rep_a),
    .mux_out(out_a), .mux_select(sel_a), .mux_valid(valid_a), .mux_frame(frame_a),
    .mux_busy(busy_a), .mux_done(done_a));

  tdm_mux #(.DATA_WIDTH(8), .SLOT_CYCLES(1)) dut_b (
    .clk(clk), .reset_n(rst_n), .mux_in(in_b), .mux_start(start_b), .mux_repeat(rep_b),
    .mux_out(out_b), .mux_select(sel_b), .mux_valid(valid_b), .mux_frame(frame_b),
    .mux_busy(busy_b), .mux_done(done_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: position within the frame (-1 = idle) plus the captured word.
  int unsigned sc[2] = '{4, 1};
  int unsigned dw[2] = '{1, 8};
  int          m_pos[2];
  logic [31:0] m_cap[2];
  logic        m_done[2];

  function automatic logic [15:0] pack(logic [7:0] o, logic [1:0] s, logic v, logic f,
                                       logic b, logic d);
    return {o, 2'b00, s, v, f, b, d};
  endfunction

  function automatic logic [15:0] act_a();
    return pack(8'(out_a), sel_a, valid_a, frame_a, busy_a, done_a);
  endfunction

  function automatic logic [15:0] act_b();
    return pack(out_b, sel_b, valid_b, frame_b, busy_b, done_b);
  endfunction

  function automatic logic [15:0] model_exp(int i);
    logic        v;
    int          s;
    logic [31:0] o;
    v = (m_pos[i] >= 0);
    s = v ? m_pos[i] / int'(sc[i]) : 0;
    o = v ? ((m_cap[i] >> (s * int'(dw[i]))) & ((32'd1 << dw[i]) - 32'd1)) : 32'd0;
    return pack(o[7:0], 2'(s), v, m_pos[i] == 0, v, m_done[i]);
  endfunction

  task automatic model_edge(int i, logic st, logic rp, logic [31:0] din);
    if (!rst_n) begin
      m_pos[i]  = -1;
      m_cap[i]  = '0;
      m_done[i] = 1'b0;
    end else begin
      m_done[i] = 1'b0;
      if (m_pos[i] < 0) begin
        if (st) begin
          m_cap[i] = din;
          m_pos[i] = 0;
        end
      end else if (m_pos[i] == 4 * int'(sc[i]) - 1) begin
        m_done[i] = 1'b1;
        if (rp) begin
          m_cap[i] = din;
          m_pos[i] = 0;
        end else begin
          m_pos[i] = -1;
        end
      end else begin
        m_pos[i] = m_pos[i] + 1;
      end
    end
  endtask

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One clock: advance the model at the edge, then compare both DUTs 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge(0, start_a, rep_a, {28'd0, in_a});
    model_edge(1, start_b, rep_b, in_b);
    #1;
    chk("model_a", act_a(), model_exp(0));
    chk("model_b", act_b(), model_exp(1));
  endtask

  typedef struct {
    logic       start;
    logic [3:0] din;
    logic       out;
    logic [1:0] sel;
    logic       valid;
    logic       frame;
    logic       done;
  } vec_t;

  vec_t vecs[18];
  logic [7:0] bytes_b[4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

  initial begin
    logic [3:0]  pat;
    logic [15:0] exp;
    int          s;

    // Single frame of 1010, input changed mid-frame and a stray start while busy.
    pat = 4'b1010;
    for (int r = 0; r < 18; r++) begin
      vecs[r].start = (r == 0) || (r == 7);
      vecs[r].din   = (r < 4) ? 4'b1010 : 4'b0101;
      vecs[r].valid = (r < 16);
      vecs[r].sel   = (r < 16) ? 2'(r / 4) : 2'd0;
      vecs[r].out   = (r < 16) ? pat[vecs[r].sel] : 1'b0;
      vecs[r].frame = (r == 0);
      vecs[r].done  = (r == 16);
    end

    m_pos = '{-1, -1};
    m_cap = '{32'd0, 32'd0};
    m_done = '{1'b0, 1'b0};
    rst_n = 1'b0;
    in_a = '0; start_a = 1'b0; rep_a = 1'b0;
    in_b = '0; start_b = 1'b0; rep_b = 1'b0;

    step();
    step();
    chk("reset_a", act_a(), 16'h0000);
    chk("reset_b", act_b(), 16'h0000);
    rst_n = 1'b1;
    step();

    for (int r = 0; r < 18; r++) begin
      start_a = vecs[r].start;
      in_a    = vecs[r].din;
      step();
      exp = pack(8'(vecs[r].out), vecs[r].sel, vecs[r].valid, vecs[r].frame,
                 vecs[r].valid, vecs[r].done);
      chk($sformatf("single_row%0d", r), act_a(), exp);
    end
    start_a = 1'b0;
    step();

    // Repeat: 0011 then recaptured 1100, no gap; repeat dropped during frame 2.
    in_a = 4'b0011; rep_a = 1'b1; start_a = 1'b1;
    for (int r = 0; r < 34; r++) begin
      if (r == 1)  start_a = 1'b0;
      if (r == 10) in_a = 4'b1100;
      if (r == 20) rep_a = 1'b0;
      step();
      if (r < 16) begin
        s = r / 4;
        pat = 4'b0011;
        exp = pack(8'(pat[s]), 2'(s), 1'b1, r == 0, 1'b1, 1'b0);
      end else if (r < 32) begin
        s = (r - 16) / 4;
        pat = 4'b1100;
        exp = pack(8'(pat[s]), 2'(s), 1'b1, r == 16, 1'b1, r == 16);
      end else begin
        exp = pack(8'd0, 2'd0, 1'b0, 1'b0, 1'b0, r == 32);
      end
      chk($sformatf("repeat_row%0d", r), act_a(), exp);
    end

    // Abort mid-frame at slot 2, reset held two cycles, then a clean restart.
    in_a = 4'b1010; start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int r = 1; r < 9; r++) step();
    chk("abort_sel2", 16'(sel_a), 16'd2);
    rst_n = 1'b0;
    step();
    chk("abort_cleared", act_a(), 16'h0000);
    step();
    chk("reset_hold2", act_a(), 16'h0000);
    rst_n = 1'b1;
    for (int r = 0; r < 20; r++) begin
      step();
      chk("abort_no_done", 16'(done_a), 16'd0);
    end
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    chk("restart_slot0", act_a(), pack(8'd0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0));
    for (int r = 0; r < 18; r++) step();

    // One-clock slots, 8-bit lanes, start accepted in the done cycle.
    in_b = 32'hDDCCBBAA;
    for (int r = 0; r < 8; r++) begin
      start_b = (r == 0) || (r == 5);
      step();
      if (r < 4)
        exp = pack(bytes_b[r], 2'(r), 1'b1, r == 0, 1'b1, 1'b0);
      else if (r == 4)
        exp = pack(8'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      else
        exp = pack(bytes_b[r - 5], 2'(r - 5), 1'b1, r == 5, 1'b1, 1'b0);
      chk($sformatf("sc1_row%0d", r), act_b(), exp);
    end
    start_b = 1'b0;
    for (int r = 0; r < 6; r++) step();

    // Random traffic, including rare resets, checked against the model.
    for (int r = 0; r < 3000; r++) begin
      rst_n   = ($urandom_range(0, 199) != 0);
      start_a = ($urandom_range(0, 3) == 0);
      rep_a   = $urandom_range(0, 1) != 0;
      in_a    = 4'($urandom);
      start_b = ($urandom_range(0, 3) == 0);
      rep_b   = $urandom_range(0, 1) != 0;
      in_b    = $urandom;
      step();
    end
    rst_n = 1'b1;
    start_a = 1'b0; rep_a = 1'b0; start_b = 1'b0; rep_b = 1'b0;
    for (int r = 0; r < 20; r++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
